// File: rtl/banner_pkg.sv
// Shared types and defaults for the banner scroller: FSM encoding, geometry and
// the wrap-around adder used for the scroll offset.
package banner_pkg;

  localparam int BANNER_ROM_W = 70;
  localparam int BANNER_ROWS  = 15;
  localparam int BANNER_WIN_W = 32;
  localparam int ADDR_W       = 5;
  localparam int OFS_W        = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPT,
    S_OUT,
    S_DONE
  } state_e;

  // (a + b) mod m for a, b < m, using one compare-and-subtract
  function automatic logic [OFS_W-1:0] wrap_add(input logic [OFS_W-1:0] a,
                                                input logic [OFS_W-1:0] b,
                                                input logic [OFS_W:0]   m);
    logic [OFS_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= m) sum = sum - m;
    return sum[OFS_W-1:0];
  endfunction

endpackage

// File: rtl/banner_window.sv
// Combinational rotate-and-slice: picks WIN_W columns of the row buffer starting
// at column (ROM_W-1-offset), wrapping around the bitmap edge.
module banner_window import banner_pkg::*; #(
  parameter int WIN_W = BANNER_WIN_W,
  parameter int ROM_W = BANNER_ROM_W
) (
  input  logic [ROM_W-1:0] buf_i,
  input  logic [OFS_W-1:0] offset_i,
  output logic [WIN_W-1:0] win_o
);

  localparam int DW = $clog2(2 * ROM_W);

  // A doubled copy of the row turns the modulo wrap into a plain slice.
  logic [2*ROM_W-1:0] dbl;
  logic [DW-1:0]      base;

  assign dbl   = {buf_i, buf_i};
  assign base  = DW'(2 * ROM_W - 1) - DW'(offset_i);
  assign win_o = dbl[base -: WIN_W];

endmodule

// File: rtl/banner_scroller.sv
// Banner scroller: reads ROWS bitmap rows from a 1-cycle-latency ROM and streams
// a WIN_W-pixel window per row. Define BANNER_SCROLL_EN to advance the window by
// STEP columns after every frame; otherwise the window is fixed at offset 0.
module banner_scroller import banner_pkg::*; #(
  parameter int WIN_W = BANNER_WIN_W,
  parameter int ROM_W = BANNER_ROM_W,
  parameter int ROWS  = BANNER_ROWS,
  parameter int STEP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [ROM_W-1:0]  rom_data,
  output logic [WIN_W-1:0]  row_data,
  output logic [ADDR_W-1:0] row_index,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  if (STEP < 0 || STEP >= ROM_W || WIN_W < 1 || WIN_W > ROM_W) begin : g_param_chk
    $error("banner_scroller: parameter out of range");
  end

  state_e            state_q;
  logic [ADDR_W-1:0] row_cnt_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ROM_W-1:0]  buf_q;
  logic [ADDR_W-1:0] row_idx_q;
  logic              row_vld_q;
  logic              busy_q;
  logic              done_q;
  logic [OFS_W-1:0]  offset;

`ifdef BANNER_SCROLL_EN
  logic [OFS_W-1:0] offset_q;
  logic [OFS_W-1:0] offset_d;

  assign offset_d = wrap_add(offset_q, OFS_W'(STEP), (OFS_W+1)'(ROM_W));

  always_ff @(posedge clk) begin
    if (!rst_n)                offset_q <= '0;
    else if (state_q == S_DONE) offset_q <= offset_d;
  end

  assign offset = offset_q;
`else
  assign offset = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      rom_addr_q <= '0;
      buf_q      <= '0;
      row_idx_q  <= '0;
      row_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_ADDR;
            row_cnt_q  <= '0;
            rom_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        S_ADDR: state_q <= S_CAPT;
        // ROM data for the address presented in ADDR is valid now
        S_CAPT: begin
          buf_q     <= rom_data;
          row_idx_q <= row_cnt_q;
          row_vld_q <= 1'b1;
          state_q   <= S_OUT;
        end
        S_OUT: begin
          if (row_ready) begin
            row_vld_q <= 1'b0;
            if (row_cnt_q == LAST_ROW) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              row_cnt_q  <= row_cnt_q + 1'b1;
              rom_addr_q <= row_cnt_q + 1'b1;
              state_q    <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  banner_window #(
    .WIN_W (WIN_W),
    .ROM_W (ROM_W)
  ) u_win (
    .buf_i    (buf_q),
    .offset_i (offset),
    .win_o    (row_data)
  );

  assign rom_address = rom_addr_q;
  assign row_index   = row_idx_q;
  assign row_valid   = row_vld_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_banner_scroller.sv
// Randomized bench for banner_scroller: a behavioural ROM plus a modulo-arithmetic
// window model; random downstream stalls, mid-frame start and reset abort.
module tb_banner_scroller;

  localparam int WIN_W   = 32;
  localparam int ROM_W   = 70;
  localparam int ROWS    = 15;
  localparam int TB_STEP = 60;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [4:0]       rom_address;
  logic [ROM_W-1:0] rom_data = '0;
  logic [WIN_W-1:0] row_data;
  logic [4:0]       row_index;
  logic             row_valid;
  logic             row_ready = 1'b0;
  logic             busy;
  logic             frame_done;

  logic [ROM_W-1:0] rom [32];
  int n_vec = 0;
  int n_err = 0;
  int off   = 0;
  int fidx  = 0;

  banner_scroller #(
    .WIN_W (WIN_W),
    .ROM_W (ROM_W),
    .ROWS  (ROWS),
    .STEP  (TB_STEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .row_data    (row_data),
    .row_index   (row_index),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_address];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIN_W-1:0] exp_row(input int r, input int o);
    logic [WIN_W-1:0] v;
    for (int k = 0; k < WIN_W; k++)
      v[WIN_W-1-k] = rom[r][ROM_W-1-((o + k) % ROM_W)];
    return v;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, rom_address, 0);
    chk({tag, "_data"}, row_data, 0);
    chk({tag, "_idx"},  row_index, 0);
    chk({tag, "_vld"},  row_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fd"},   frame_done, 0);
  endtask

  task automatic run_frame(input int abort_row, input bit poke);
    logic [WIN_W-1:0] e;
    int w;
    int stall;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on", busy, 1);
    for (int r = 0; r < ROWS; r++) begin
      w = 0;
      while (!row_valid && w < 8) begin
        start = (poke && r == 4 && w == 0);
        tick();
        w++;
      end
      start = 1'b0;
      chk("latency", w, 2);
      chk("addr", rom_address, r);
      e = exp_row(r, off);
      if (abort_row == r) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset("abort");
        for (int i = 0; i < 3; i++) begin
          tick();
          chk("abort_fd", frame_done, 0);
          chk("abort_busy", busy, 0);
        end
        off  = 0;
        fidx = 0;
        return;
      end
      stall = (r == 6) ? 5 : $urandom_range(0, 2);
      row_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        chk("hold_vld", row_valid, 1);
        chk("hold_data", row_data, e);
        chk("hold_addr", rom_address, r);
        tick();
      end
      chk("valid", row_valid, 1);
      chk("data", row_data, e);
      chk("index", row_index, r);
      chk("fd_mid", frame_done, 0);
      if (fidx == 0 && r == 0) chk("row0_std", row_data, 32'hFC0FC0FF);
      if (fidx == 0 && r == 3) chk("row3_std", row_data, 32'hE38E38E0);
`ifdef BANNER_SCROLL_EN
      if (fidx == 1 && r == 0) chk("row0_wrap", row_data, 32'h007F03F0);
`endif
      row_ready = 1'b1;
      tick();
      row_ready = 1'b0;
    end
    chk("frame_done", frame_done, 1);
    start = poke;
    tick();
    start = 1'b0;
    chk("fd_pulse", frame_done, 0);
    chk("busy_off", busy, 0);
    tick();
    chk("idle", busy, 0);
`ifdef BANNER_SCROLL_EN
    off = (off + TB_STEP) % ROM_W;
`endif
    fidx++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      rom[i] = (i < ROWS) ? ROM_W'({$urandom(), $urandom(), $urandom()}) : '0;
    rom[0][69:38] = 32'hFC0FC0FF;
    rom[0][9:0]   = 10'd1;
    rom[3][69:38] = 32'hE38E38E0;

    rst_n = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    run_frame(-1, 1'b1);
    run_frame(-1, 1'b0);
    run_frame(8, 1'b0);
    run_frame(-1, 1'b1);
    for (int f = 0; f < 3; f++) run_frame(-1, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
